// File: rtl/vx_bar_sched_pkg.sv
// Shared types and sizing for the local barrier unit.
//   NUM_WARPS / NUM_BARRIERS : core warp count and barrier slot count
//   NW_W / NB_W              : warp-id and slot-id widths (never below 1)
//   bar_req_t                : decoded barrier request fields
//   warp_bit()               : one-hot warp mask from a warp id
package vx_bar_sched_pkg;

  localparam int NUM_WARPS    = 4;
  localparam int NUM_BARRIERS = 8;
  localparam int NW_W = (NUM_WARPS    > 1) ? $clog2(NUM_WARPS)    : 1;
  localparam int NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  typedef struct packed {
    logic [NB_W-1:0] id;
    logic [NW_W-1:0] size_m1;
    logic            is_arrive;
    logic            is_async;
    logic            phase;
  } bar_req_t;

  function automatic logic [NUM_WARPS-1:0] warp_bit(input logic [NW_W-1:0] wid);
    return NUM_WARPS'(1) << wid;
  endfunction

endpackage

// File: rtl/vx_bar_unlock_buf.sv
// Merging unlock holding register with a valid/ready output.
//   clk, reset     : clock, async active-high reset
//   released       : warps released this cycle (may be empty)
//   unlock_valid   : holding register non-empty
//   unlock_ready   : scheduler accepts the current mask
//   unlock_mask    : warps to release
// A stalled mask is kept and new releases are OR-ed in, so no event is
// ever lost and the presented mask only gains bits under back-pressure.
module vx_bar_unlock_buf
  import vx_bar_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WARPS-1:0] released,
  output logic                 unlock_valid,
  input  logic                 unlock_ready,
  output logic [NUM_WARPS-1:0] unlock_mask
);

  logic [NUM_WARPS-1:0] mask_next;

  assign mask_next = ((unlock_valid && !unlock_ready) ? unlock_mask : '0) | released;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      unlock_mask  <= '0;
      unlock_valid <= 1'b0;
    end else begin
      unlock_mask  <= mask_next;
      unlock_valid <= |mask_next;
    end
  end

endmodule

// File: rtl/vx_bar_sched.sv
// Local barrier unit for one core, feeding the warp scheduler.
//   clk, reset        : clock, async active-high reset
//   req_*             : barrier arrive / wait request (valid/ready)
//   read_addr/phase   : combinational phase query with same-cycle bypass
//   flush_valid/id    : abort a slot; blocks requests that cycle
//   unlock_*          : merged release mask towards the scheduler
//   bar_active        : per-slot busy flag
module vx_bar_sched
  import vx_bar_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [NW_W-1:0]         req_wid,
  input  logic [NB_W-1:0]         req_id,
  input  logic [NW_W-1:0]         req_size_m1,
  input  logic                    req_is_arrive,
  input  logic                    req_is_async,
  input  logic                    req_phase,
  input  logic [NB_W-1:0]         read_addr,
  output logic                    read_phase,
  input  logic                    flush_valid,
  input  logic [NB_W-1:0]         flush_id,
  output logic                    unlock_valid,
  input  logic                    unlock_ready,
  output logic [NUM_WARPS-1:0]    unlock_mask,
  output logic [NUM_BARRIERS-1:0] bar_active
);

  logic [NUM_WARPS-1:0] slot_mask  [NUM_BARRIERS];
  logic [NW_W-1:0]      slot_count [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] slot_phase;

  bar_req_t             req;
  logic                 fire;
  logic [NUM_WARPS-1:0] wbit;
  logic [NUM_WARPS-1:0] cur_mask;
  logic [NW_W-1:0]      cur_count;
  logic                 cur_phase;

  logic                 upd_en;
  logic [NB_W-1:0]      upd_id;
  logic [NUM_WARPS-1:0] upd_mask;
  logic [NW_W-1:0]      upd_count;
  logic                 upd_phase;
  logic [NUM_WARPS-1:0] released;

  always_comb begin
    req.id        = req_id;
    req.size_m1   = req_size_m1;
    req.is_arrive = req_is_arrive;
    req.is_async  = req_is_async;
    req.phase     = req_phase;
  end

  // Flush owns the single update port, so requests are refused that cycle.
  assign req_ready = ~flush_valid;
  assign fire      = req_valid & req_ready;
  assign wbit      = warp_bit(req_wid);
  assign cur_mask  = slot_mask[req.id];
  assign cur_count = slot_count[req.id];
  assign cur_phase = slot_phase[req.id];

  always_comb begin
    upd_en    = 1'b0;
    upd_id    = req.id;
    upd_mask  = cur_mask;
    upd_count = cur_count;
    upd_phase = cur_phase;
    released  = '0;
    if (flush_valid) begin
      upd_en    = 1'b1;
      upd_id    = flush_id;
      upd_mask  = '0;
      upd_count = '0;
      upd_phase = slot_phase[flush_id];
      released  = slot_mask[flush_id];
    end else if (fire) begin
      upd_en = 1'b1;
      if (req.is_arrive) begin
        if (cur_count == req.size_m1) begin
          upd_mask  = '0;
          upd_count = '0;
          upd_phase = ~cur_phase;
          released  = cur_mask | (req.is_async ? '0 : wbit);
        end else begin
          upd_count = cur_count + NW_W'(1);
          if (!req.is_async) upd_mask = cur_mask | wbit;
        end
      end else if (req.phase != cur_phase) begin
        // Phase already advanced past what the warp saw: release at once.
        released = wbit;
      end else begin
        upd_mask = cur_mask | wbit;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        slot_mask[i]  <= '0;
        slot_count[i] <= '0;
      end
      slot_phase <= '0;
    end else if (upd_en) begin
      slot_mask[upd_id]  <= upd_mask;
      slot_count[upd_id] <= upd_count;
      slot_phase[upd_id] <= upd_phase;
    end
  end

  assign read_phase = (upd_en && upd_id == read_addr) ? upd_phase : slot_phase[read_addr];

  always_comb begin
    bar_active = '0;
    for (int i = 0; i < NUM_BARRIERS; i++)
      bar_active[i] = (slot_count[i] != '0) || (slot_mask[i] != '0);
  end

  vx_bar_unlock_buf u_unlock_buf (
    .clk          (clk),
    .reset        (reset),
    .released     (released),
    .unlock_valid (unlock_valid),
    .unlock_ready (unlock_ready),
    .unlock_mask  (unlock_mask)
  );

endmodule

// File: tb/tb_vx_bar_sched.sv
// Self-checking bench for vx_bar_sched: directed scenarios plus random
// arrive/wait/flush traffic against a behavioural slot model.
module tb_vx_bar_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_wid;
  logic [2:0] req_id;
  logic [1:0] req_size_m1;
  logic       req_is_arrive;
  logic       req_is_async;
  logic       req_phase;
  logic [2:0] read_addr;
  logic       read_phase;
  logic       flush_valid;
  logic [2:0] flush_id;
  logic       unlock_valid;
  logic       unlock_ready;
  logic [3:0] unlock_mask;
  logic [7:0] bar_active;

  vx_bar_sched dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
    .req_id(req_id), .req_size_m1(req_size_m1), .req_is_arrive(req_is_arrive),
    .req_is_async(req_is_async), .req_phase(req_phase),
    .read_addr(read_addr), .read_phase(read_phase),
    .flush_valid(flush_valid), .flush_id(flush_id),
    .unlock_valid(unlock_valid), .unlock_ready(unlock_ready),
    .unlock_mask(unlock_mask), .bar_active(bar_active)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: per-slot waiting set, arrival count, phase; pending unlocks.
  int m_mask [8];
  int m_cnt  [8];
  int m_ph   [8];
  int m_u;
  int m_uv;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mask[i] = 0; m_cnt[i] = 0; m_ph[i] = 0;
    end
    m_u = 0; m_uv = 0;
  endtask

  task automatic set_req(input bit v, input int wid, input int id, input int sm1,
                         input bit arr, input bit asy, input bit ph);
    req_valid = v; req_wid = wid[1:0]; req_id = id[2:0]; req_size_m1 = sm1[1:0];
    req_is_arrive = arr; req_is_async = asy; req_phase = ph;
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic tick();
    int rel, nid, nmask, ncnt, nph, upd, rp_e, w, act;
    #1;
    upd = 0; rel = 0; nid = 0; nmask = 0; ncnt = 0; nph = 0;
    if (flush_valid) begin
      upd = 1; nid = flush_id; nmask = 0; ncnt = 0; nph = m_ph[nid]; rel = m_mask[nid];
    end else if (req_valid) begin
      upd = 1; nid = req_id; w = 1 << req_wid;
      nmask = m_mask[nid]; ncnt = m_cnt[nid]; nph = m_ph[nid];
      if (req_is_arrive) begin
        if (m_cnt[nid] == req_size_m1) begin
          rel = m_mask[nid] | (req_is_async ? 0 : w);
          nmask = 0; ncnt = 0; nph = 1 - nph;
        end else begin
          ncnt = (ncnt + 1) % 4;
          if (!req_is_async) nmask = nmask | w;
        end
      end else if (req_phase != m_ph[nid]) rel = w;
      else nmask = nmask | w;
    end
    rp_e = (upd != 0 && nid == read_addr) ? nph : m_ph[read_addr];
    chk("req_ready", req_ready, !flush_valid);
    chk("read_phase", read_phase, rp_e);
    @(posedge clk); #1;
    if (upd != 0) begin
      m_mask[nid] = nmask; m_cnt[nid] = ncnt; m_ph[nid] = nph;
    end
    m_u  = ((m_uv != 0 && !unlock_ready) ? m_u : 0) | rel;
    m_uv = (m_u != 0);
    act = 0;
    for (int i = 0; i < 8; i++) if (m_cnt[i] != 0 || m_mask[i] != 0) act |= (1 << i);
    chk("unlock_valid", unlock_valid, m_uv);
    chk("unlock_mask", unlock_mask, m_u);
    chk("bar_active", bar_active, act);
    @(negedge clk);
  endtask

  task automatic idle();
    set_req(0, 0, 0, 0, 0, 0, 0);
    flush_valid = 0; unlock_ready = 1;
    tick();
  endtask

  initial begin
    reset = 1;
    set_req(0, 0, 0, 0, 0, 0, 0);
    read_addr = 0; flush_valid = 0; flush_id = 0; unlock_ready = 1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_unlock_valid", unlock_valid, 0);
    chk("rst_bar_active", bar_active, 0);
    reset = 0;

    // 1: four sync arrives on slot 2
    read_addr = 2;
    for (int w = 0; w < 4; w++) begin
      set_req(1, w, 2, 3, 1, 0, 0);
      tick();
    end
    chk("t1_mask", unlock_mask, 4'b1111);
    set_req(0, 0, 0, 0, 0, 0, 0); #1;
    chk("t1_phase", read_phase, 1);
    idle();

    // 2: async arrive + sync arrive, then late wait releases immediately
    set_req(1, 1, 0, 1, 1, 1, 0); tick();
    set_req(1, 2, 0, 1, 1, 0, 0); tick();
    chk("t2_mask", unlock_mask, 4'b0100);
    set_req(1, 1, 0, 0, 0, 0, 0); tick();
    chk("t2_wait_mask", unlock_mask, 4'b0010);
    idle();

    // 3: back-pressure merges two completions
    unlock_ready = 0;
    set_req(1, 0, 1, 1, 1, 0, 0); tick();
    set_req(1, 2, 3, 1, 1, 0, 0); tick();
    set_req(1, 1, 1, 1, 1, 0, 0); tick();
    set_req(1, 3, 3, 1, 1, 0, 0); tick();
    chk("t3_merged", unlock_mask, 4'b1111);
    set_req(0, 0, 0, 0, 0, 0, 0); unlock_ready = 1; tick();
    chk("t3_drop", unlock_valid, 0);

    // 4: flush of slot 5 with two blocked warps and a colliding request
    read_addr = 5;
    set_req(1, 0, 5, 3, 0, 0, 0); tick();
    set_req(1, 2, 5, 3, 0, 0, 0); tick();
    set_req(1, 1, 5, 3, 1, 0, 0); flush_valid = 1; flush_id = 5;
    #1 chk("t4_ready", req_ready, 0);
    tick();
    flush_valid = 0;
    chk("t4_mask", unlock_mask, 4'b0101);
    chk("t4_active", bar_active[5], 0);
    chk("t4_phase", read_phase, 0);
    idle();

    // 5: same-cycle read bypass on completion
    read_addr = 4;
    set_req(1, 3, 4, 0, 1, 0, 0);
    #1 chk("t5_bypass", read_phase, 1);
    tick();
    idle();

    // 6: async reset with an unlock pending
    unlock_ready = 0;
    set_req(1, 0, 6, 0, 1, 0, 0); tick();
    chk("t6_pending", unlock_valid, 1);
    set_req(0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1;
    #1 chk("t6_unlock_valid", unlock_valid, 0);
    chk("t6_unlock_mask", unlock_mask, 0);
    chk("t6_active", bar_active, 0);
    for (int a = 0; a < 8; a++) begin
      read_addr = a[2:0];
      #1 chk("t6_phase", read_phase, 0);
    end
    model_reset();
    @(negedge clk);
    reset = 0;
    unlock_ready = 1;

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      set_req(($urandom % 4) != 0, $urandom % 4, $urandom % 8, $urandom % 4,
              $urandom % 2, ($urandom % 4) == 0, $urandom % 2);
      flush_valid  = (($urandom % 10) == 0);
      flush_id     = 3'($urandom % 8);
      read_addr    = 3'($urandom % 8);
      unlock_ready = ($urandom % 3) != 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
